// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type, data cache FSM states and fixed addresses.
// No ports; imported by the pdcache files.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    ALLOC,
    FLUSH,
    CNT,
    DONE
  } state_t;

  localparam word_t HITCNT_ADDR = 32'h3100;

endpackage

// File: rtl/pdcache_if.sv
// pdcache_if: datapath-side request port and memory-side transfer port.
// slave = cache view, master = datapath/memory (testbench) view.
interface pdcache_if;
  import cpu_types_pkg::*;

  logic  halt;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;
  logic  flushed;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dwait, dload,
    output dhit, dmemload, flushed,
    output dREN, dWEN, daddr, dstore
  );

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dwait, dload,
    input  dhit, dmemload, flushed,
    input  dREN, dWEN, daddr, dstore
  );

endinterface

// File: rtl/pdcache_array.sv
// pdcache_array: two-way line storage, tag compare and per-set LRU bits.
// Ports: idx/word/tag read select, per-way hit/valid/dirty/tag/word, write controls.
module pdcache_array
  import cpu_types_pkg::*;
#(
  parameter  int SETS     = 8,
  parameter  int BLKWORDS = 2,
  localparam int IW       = $clog2(SETS),
  localparam int BOFF     = $clog2(BLKWORDS),
  localparam int WW       = (BOFF > 0) ? BOFF : 1,
  localparam int TW       = 30 - IW - BOFF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [IW-1:0]        idx_i,
  input  logic [WW-1:0]        word_i,
  input  logic [TW-1:0]        tag_i,
  output logic [1:0]           hit_o,
  output logic [1:0]           valid_o,
  output logic [1:0]           dirty_o,
  output logic [1:0][TW-1:0]   tag_o,
  output word_t [1:0]          word_o,
  output logic                 lru_o,
  input  logic                 wr_way_i,
  input  logic                 we_word_i,
  input  logic                 set_dirty_i,
  input  word_t                wdata_i,
  input  logic                 fill_i,
  input  logic                 clr_dirty_i,
  input  logic                 lru_we_i,
  input  logic                 lru_i,
  input  logic                 clr_valid_i
);

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TW-1:0]              tag;
    word_t [BLKWORDS-1:0]       data;
  } line_t;

  line_t           lines_q [2][SETS];
  logic [SETS-1:0] lru_q;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      valid_o[w] = lines_q[w][idx_i].valid;
      dirty_o[w] = lines_q[w][idx_i].dirty;
      tag_o[w]   = lines_q[w][idx_i].tag;
      word_o[w]  = lines_q[w][idx_i].data[word_i];
      hit_o[w]   = valid_o[w] && (tag_o[w] == tag_i);
    end
    lru_o = lru_q[idx_i];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++)
          lines_q[w][s] <= '0;
      lru_q <= '0;
    end else begin
      if (clr_valid_i)
        for (int w = 0; w < 2; w++)
          for (int s = 0; s < SETS; s++)
            lines_q[w][s].valid <= 1'b0;
      if (we_word_i) begin
        lines_q[wr_way_i][idx_i].data[word_i] <= wdata_i;
        if (set_dirty_i)
          lines_q[wr_way_i][idx_i].dirty <= 1'b1;
      end
      if (fill_i) begin
        lines_q[wr_way_i][idx_i].valid <= 1'b1;
        lines_q[wr_way_i][idx_i].dirty <= 1'b0;
        lines_q[wr_way_i][idx_i].tag   <= tag_i;
      end
      if (clr_dirty_i)
        lines_q[wr_way_i][idx_i].dirty <= 1'b0;
      if (lru_we_i)
        lru_q[idx_i] <= lru_i;
    end
  end

endmodule

// File: rtl/pdcache.sv
// pdcache: 2-way write-back/write-allocate data cache with sequenced halt flush.
// Ports: CLK, nRST, dif (pdcache_if.slave). Option: PDCACHE_HITCNT_EN adds hit counter.
module pdcache
  import cpu_types_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input logic      CLK,
  input logic      nRST,
  pdcache_if.slave dif
);

  localparam int IW   = $clog2(SETS);
  localparam int BOFF = $clog2(BLKWORDS);
  localparam int WW   = (BOFF > 0) ? BOFF : 1;
  localparam int TW   = 30 - IW - BOFF;
  localparam logic [WW-1:0] LASTW = WW'(BLKWORDS - 1);
  localparam logic [IW-1:0] LASTS = IW'(SETS - 1);
`ifdef PDCACHE_HITCNT_EN
  localparam state_t SCAN_END = CNT;
`else
  localparam state_t SCAN_END = DONE;
`endif

  state_t        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [IW-1:0] s_q, s_d;
  logic          v_q, v_d;
  logic          vic_q, vic_d;
`ifdef PDCACHE_HITCNT_EN
  word_t         cnt_q, cnt_d;
`endif

  word_t         wa;
  logic [WW-1:0] r_off;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tag;

  assign wa    = dif.dmemaddr >> 2;
  assign r_off = WW'(wa) & LASTW;
  assign r_idx = IW'(wa >> BOFF);
  assign r_tag = TW'(wa >> (BOFF + IW));

  logic [IW-1:0]      a_idx;
  logic [WW-1:0]      a_word;
  logic [1:0]         hit, valid, dirty;
  logic [1:0][TW-1:0] tags;
  word_t [1:0]        words;
  logic               lru;
  logic               wr_way, we_word, set_dirty, fill;
  logic               clr_dirty, lru_we, lru_n, clr_valid;
  word_t              wdata;

  // Flush scans by pointer; every other state works on the request set.
  assign a_idx  = (state_q == FLUSH) ? s_q : r_idx;
  assign a_word = (state_q == IDLE) ? r_off : w_q;

  pdcache_array #(
    .SETS     (SETS),
    .BLKWORDS (BLKWORDS)
  ) u_array (
    .CLK         (CLK),
    .nRST        (nRST),
    .idx_i       (a_idx),
    .word_i      (a_word),
    .tag_i       (r_tag),
    .hit_o       (hit),
    .valid_o     (valid),
    .dirty_o     (dirty),
    .tag_o       (tags),
    .word_o      (words),
    .lru_o       (lru),
    .wr_way_i    (wr_way),
    .we_word_i   (we_word),
    .set_dirty_i (set_dirty),
    .wdata_i     (wdata),
    .fill_i      (fill),
    .clr_dirty_i (clr_dirty),
    .lru_we_i    (lru_we),
    .lru_i       (lru_n),
    .clr_valid_i (clr_valid)
  );

  logic req, hitnow, hway, lastw, flast, fdirty, vic_sel;

  assign req    = dif.dmemREN | dif.dmemWEN;
  assign hitnow = (state_q == IDLE) && req && (|hit);
  assign hway   = hit[1];
  assign lastw  = (w_q == LASTW);
  assign flast  = (s_q == LASTS) && v_q;
  assign fdirty = valid[v_q] && dirty[v_q];
  // Fill an empty way before evicting anything.
  assign vic_sel = !valid[0] ? 1'b0 :
                   !valid[1] ? 1'b1 : lru;

  function automatic word_t mk_addr(
    input logic [TW-1:0] t,
    input logic [IW-1:0] i,
    input logic [WW-1:0] w
  );
    word_t a;
    a = (32'(t) << (IW + BOFF)) | (32'(i) << BOFF) | 32'(w & LASTW);
    return a << 2;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      w_q     <= '0;
      s_q     <= '0;
      v_q     <= 1'b0;
      vic_q   <= 1'b0;
`ifdef PDCACHE_HITCNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
      v_q     <= v_d;
      vic_q   <= vic_d;
`ifdef PDCACHE_HITCNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    v_d     = v_q;
    vic_d   = vic_q;
`ifdef PDCACHE_HITCNT_EN
    cnt_d   = hitnow ? cnt_q + 32'd1 : cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hitnow) begin
          state_d = IDLE;
        end else if (dif.halt) begin
          state_d = FLUSH;
          s_d     = '0;
          v_d     = 1'b0;
          w_d     = '0;
        end else if (req) begin
          vic_d   = vic_sel;
          w_d     = '0;
          state_d = (valid[vic_sel] && dirty[vic_sel]) ? WB : ALLOC;
        end
      end
      WB: begin
        if (!dif.dwait) begin
          w_d = w_q + WW'(1);
          if (lastw) begin
            w_d     = '0;
            state_d = ALLOC;
          end
        end
      end
      ALLOC: begin
        if (!dif.dwait) begin
          w_d = w_q + WW'(1);
          if (lastw) begin
            w_d     = '0;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (!fdirty || (!dif.dwait && lastw)) begin
          w_d = '0;
          if (flast) begin
            state_d = SCAN_END;
          end else begin
            v_d = ~v_q;
            if (v_q)
              s_d = s_q + IW'(1);
          end
        end else if (!dif.dwait) begin
          w_d = w_q + WW'(1);
        end
      end
      CNT: begin
        if (!dif.dwait)
          state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dif.dhit     = hitnow;
    dif.dmemload = hitnow ? words[hway] : '0;
    dif.flushed  = (state_q == DONE);
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = '0;
    dif.dstore   = '0;
    wr_way       = vic_q;
    we_word      = 1'b0;
    set_dirty    = 1'b0;
    wdata        = dif.dload;
    fill         = 1'b0;
    clr_dirty    = 1'b0;
    lru_we       = 1'b0;
    lru_n        = 1'b0;
    clr_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hitnow) begin
          wr_way = hway;
          lru_we = 1'b1;
          lru_n  = ~hway;
          if (dif.dmemWEN) begin
            we_word   = 1'b1;
            set_dirty = 1'b1;
            wdata     = dif.dmemstore;
          end
        end
      end
      WB: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = mk_addr(tags[vic_q], r_idx, w_q);
        dif.dstore = words[vic_q];
        clr_dirty  = !dif.dwait && lastw;
      end
      ALLOC: begin
        dif.dREN  = 1'b1;
        dif.daddr = mk_addr(r_tag, r_idx, w_q);
        we_word   = !dif.dwait;
        fill      = !dif.dwait && lastw;
      end
      FLUSH: begin
        wr_way = v_q;
        if (fdirty) begin
          dif.dWEN   = 1'b1;
          dif.daddr  = mk_addr(tags[v_q], s_q, w_q);
          dif.dstore = words[v_q];
          clr_dirty  = !dif.dwait && lastw;
        end
      end
`ifdef PDCACHE_HITCNT_EN
      CNT: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = HITCNT_ADDR;
        dif.dstore = cnt_q;
      end
`endif
      DONE: clr_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pdcache.sv
// tb_pdcache: directed bench for pdcache (8x2 and 16x4 builds) with memory responders.
// Ports: none. Hit-count write checked when PDCACHE_HITCNT_EN is defined.
module tb_pdcache;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  pdcache_if ifa ();
  pdcache_if ifb ();

  pdcache #(.SETS(8), .BLKWORDS(2)) u_a (
    .CLK (CLK), .nRST (nRST), .dif (ifa.slave)
  );
  pdcache #(.SETS(16), .BLKWORDS(4)) u_b (
    .CLK (CLK), .nRST (nRST), .dif (ifb.slave)
  );

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory A: programmable wait states, write log, backing store.
  int    wn_a = 0;
  int    cnt_a = 0;
  int    nrd_a = 0;
  word_t a0_a;
  word_t mem_a [word_t];
  word_t rq_a [$];
  word_t wqa_a [$];
  word_t wqd_a [$];

  always @(negedge CLK) begin
    if (ifa.dREN || ifa.dWEN) begin
      if (cnt_a == 0) a0_a = ifa.daddr;
      if (cnt_a < wn_a) begin
        ifa.dwait = 1'b1;
        cnt_a++;
      end else begin
        ifa.dwait = 1'b0;
        cnt_a = 0;
        if (wn_a > 0) check("addr_stable", ifa.daddr, a0_a);
        check("ren_wen_excl", 32'(ifa.dREN & ifa.dWEN), 0);
        if (ifa.dREN) begin
          ifa.dload = mem_a.exists(ifa.daddr) ? mem_a[ifa.daddr]
                    : 32'hA5A50000 + ((ifa.daddr >> 2) & 32'd1);
          rq_a.push_back(ifa.daddr);
          nrd_a++;
        end else begin
          mem_a[ifa.daddr] = ifa.dstore;
          wqa_a.push_back(ifa.daddr);
          wqd_a.push_back(ifa.dstore);
        end
      end
    end else begin
      ifa.dwait = 1'b0;
      cnt_a = 0;
    end
  end

  // Memory B: zero wait, read-only pattern.
  word_t rq_b [$];

  always @(negedge CLK) begin
    ifb.dwait = 1'b0;
    if (ifb.dREN) begin
      ifb.dload = 32'hA5A50000 + ((ifb.daddr >> 2) & 32'd3);
      rq_b.push_back(ifb.daddr);
    end
  end

  task automatic acc(input int d, input logic we, input word_t a,
                     input word_t wd, output word_t rd, output int lat);
    logic h;
    if (d == 0) begin
      ifa.dmemREN = !we; ifa.dmemWEN = we;
      ifa.dmemaddr = a;  ifa.dmemstore = wd;
    end else begin
      ifb.dmemREN = !we; ifb.dmemWEN = we;
      ifb.dmemaddr = a;  ifb.dmemstore = wd;
    end
    rd = '0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      h = (d == 0) ? ifa.dhit : ifb.dhit;
      if (h) begin
        rd = (d == 0) ? ifa.dmemload : ifb.dmemload;
        lat = i;
        break;
      end
    end
    if (lat < 0) check("acc_timeout", 0, 1);
    @(posedge CLK);
    #1;
    ifa.dmemREN = 1'b0; ifa.dmemWEN = 1'b0;
    ifb.dmemREN = 1'b0; ifb.dmemWEN = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t rd;
    int    lat;
    int    n0;
    word_t exp_a [6];
    word_t exp_d [6];

    nRST = 1'b0;
    ifa.halt = 0; ifa.dmemREN = 0; ifa.dmemWEN = 0;
    ifa.dmemaddr = 0; ifa.dmemstore = 0;
    ifb.halt = 0; ifb.dmemREN = 0; ifb.dmemWEN = 0;
    ifb.dmemaddr = 0; ifb.dmemstore = 0;
    repeat (2) @(negedge CLK);
    check("rst_dhit", 32'(ifa.dhit), 0);
    check("rst_dmemload", ifa.dmemload, 0);
    check("rst_flushed", 32'(ifa.flushed), 0);
    check("rst_dren", 32'(ifa.dREN), 0);
    check("rst_dwen", 32'(ifa.dWEN), 0);
    check("rst_daddr", ifa.daddr, 0);
    check("rst_dstore", ifa.dstore, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold read: two-word refill, hit on the following cycle.
    acc(0, 0, 32'h40, 0, rd, lat);
    check("cold_lat", lat, 3);
    check("cold_data", rd, 32'hA5A50000);
    check("cold_nrd", nrd_a, 2);
    check("cold_a0", rq_a[0], 32'h40);
    check("cold_a1", rq_a[1], 32'h44);

    acc(0, 1, 32'h40, 32'h1234, rd, lat);
    check("wr_hit_lat", lat, 0);
    acc(0, 0, 32'h40, 0, rd, lat);
    check("rd_back_lat", lat, 0);
    check("rd_back_data", rd, 32'h1234);
    check("rd_back_nrd", nrd_a, 2);
    check("rd_back_nwr", wqa_a.size(), 0);

    // Set 0: both ways dirty, then a third tag evicts the LRU way.
    acc(0, 1, 32'h80, 32'h5555, rd, lat);
    check("way1_lat", lat, 3);
    wn_a = 3;
    acc(0, 0, 32'hC0, 0, rd, lat);
    wn_a = 0;
    check("evict_lat", lat, 17);
    check("evict_data", rd, 32'hA5A50000);
    check("evict_nwr", wqa_a.size(), 2);
    check("evict_wa0", wqa_a[0], 32'h40);
    check("evict_wd0", wqd_a[0], 32'h1234);
    check("evict_wa1", wqa_a[1], 32'h44);
    check("evict_wd1", wqd_a[1], 32'hA5A50001);

    // Three dirty lines, then halt.
    acc(0, 1, 32'hC0, 32'h77, rd, lat);
    check("c0_wr_lat", lat, 0);
    acc(0, 1, 32'h48, 32'h99, rd, lat);
    check("s1_wr_lat", lat, 3);
    wqa_a.delete();
    wqd_a.delete();
    wn_a = 1;
    ifa.halt = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (ifa.flushed) break;
    end
    check("flushed", 32'(ifa.flushed), 1);
    exp_a = '{32'hC0, 32'hC4, 32'h80, 32'h84, 32'h48, 32'h4C};
    exp_d = '{32'h77, 32'hA5A50001, 32'h5555, 32'hA5A50001,
              32'h99, 32'hA5A50001};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("flush_a%0d", i), wqa_a[i], exp_a[i]);
      check($sformatf("flush_d%0d", i), wqd_a[i], exp_d[i]);
    end
`ifdef PDCACHE_HITCNT_EN
    check("flush_nwr", wqa_a.size(), 7);
    check("cnt_addr", wqa_a[6], HITCNT_ADDR);
    check("cnt_data", wqd_a[6], 7);
`else
    check("flush_nwr", wqa_a.size(), 6);
`endif
    wn_a = 0;
    @(posedge CLK);
    #1;
    ifa.dmemREN = 1'b1;
    ifa.dmemaddr = 32'h40;
    @(negedge CLK);
    check("done_dhit", 32'(ifa.dhit), 0);
    check("done_dren", 32'(ifa.dREN), 0);
    check("done_dwen", 32'(ifa.dWEN), 0);
    check("done_sticky", 32'(ifa.flushed), 1);
    @(posedge CLK);
    #1;
    ifa.dmemREN = 1'b0;
    ifa.halt = 1'b0;

    // Reset in the middle of a refill.
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rst2_flushed", 32'(ifa.flushed), 0);
    wn_a = 3;
    @(posedge CLK);
    #1;
    ifa.dmemREN = 1'b1;
    ifa.dmemaddr = 32'h40;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (ifa.dREN) break;
    end
    check("mid_dren_up", 32'(ifa.dREN), 1);
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_dren_drop", 32'(ifa.dREN), 0);
    check("mid_daddr_drop", ifa.daddr, 0);
    ifa.dmemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    n0 = nrd_a;
    acc(0, 0, 32'h40, 0, rd, lat);
    wn_a = 0;
    check("rerd_lat", lat, 9);
    check("rerd_nrd", nrd_a - n0, 2);
    check("rerd_data", rd, 32'h1234);

    // 16 sets x 4 words.
    acc(1, 0, 32'h0, 0, rd, lat);
    check("b_cold_lat", lat, 5);
    check("b_cold_data", rd, 32'hA5A50000);
    check("b_nrd", rq_b.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b_ra%0d", i), rq_b[i], 32'(i * 4));
    acc(1, 0, 32'h100, 0, rd, lat);
    check("b_way1_lat", lat, 5);
    acc(1, 0, 32'h0, 0, rd, lat);
    check("b_w0_hit", lat, 0);
    acc(1, 0, 32'h104, 0, rd, lat);
    check("b_w1_hit", lat, 0);
    check("b_w1_data", rd, 32'hA5A50001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pdcache.md
# pdcache

Parametrised two-way set-associative write-back, write-allocate data cache between the datapath memory port and the memory/bus controller. It generalises the fixed 8-set, 2-word-block data cache in three ways: set count and block size are parameters, victim selection prefers invalid ways, and the halt flush is sequenced. An optional hit counter is written to memory at the end of the flush.

## Interface
- SETS, 8, number of sets; power of 2, ≥2
- BLKWORDS, 2, 32-bit words per block; power of 2, 1..8
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- halt  in  1  datapath halt request; level, held until reset
- dmemREN / dmemWEN  in  1 / 1  datapath read / write request
- dmemaddr  in  32  byte address, word aligned
- dmemstore  in  32  write data
- dhit  out  1  access complete this cycle
- dmemload  out  32  read data, valid with dhit
- flushed  out  1  flush done, sticky until reset
- dREN / dWEN  out  1 / 1  memory read / write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dwait  in  1  memory busy; a transfer completes on the edge where dwait=0 with dREN/dWEN high
- dload  in  32  memory read data, valid when dwait=0

## Operation
- Address split: bytoff[1:0], blkoff (log2 BLKWORDS bits), idx (log2 SETS bits), tag (remaining bits).
- Line contents: valid, dirty, tag, data[BLKWORDS]. Each set has one LRU bit naming the way to evict next.
- States:
  - IDLE: entered from reset. Lookup is combinational. On a hit, dhit=1 and dmemload=word. On a write hit, the word is written and dirty is set on that edge. On every hit, LRU is set to the other way.
  - Miss in IDLE: pick the victim. Use the lowest invalid way if one exists, else the LRU way. Go to WB if the victim is valid and dirty, else to ALLOC.
  - WB: the word counter w runs 0..BLKWORDS-1. daddr={victim tag, idx, w, 00} and dstore=data[w]. w advances on each completed transfer. After the last word, clear dirty and go to ALLOC.
  - ALLOC: daddr={req tag, idx, w, 00} and dREN=1. dload is captured into data[w]. After the last word, set tag and valid, clear dirty, and return to IDLE. The access then hits on the next cycle.
  - FLUSH: entered from IDLE when halt=1 and no access is hitting this cycle. Scan pointer (set s, way v) starts at 0,0. A dirty valid line is written through a WB-style sequence. Clean lines advance the pointer in 1 cycle. After s=SETS-1, v=1, go to CNT (if enabled) else DONE.
  - DONE: flushed=1. All valid bits cleared. Memory outputs idle. The block stays here until reset.
- dREN and dWEN are never both high. The memory outputs are 0 in IDLE and DONE.
- Requests are ignored in FLUSH, CNT and DONE; dhit=0 there.

## Timing
- Reset values: dhit=0, dmemload=0, flushed=0, dREN=dWEN=0, daddr=0, dstore=0. All valid, dirty and LRU bits are 0, and the state is IDLE.
- Hit latency is 0 cycles: dhit is asserted in the same cycle as the request.
- Clean miss latency is BLKWORDS transfers + 1 cycle. Dirty miss latency is 2·BLKWORDS transfers + 1 cycle.
- Each transfer takes at least 1 cycle and is stretched while dwait=1. The address and data must hold stable while dwait=1.
- If halt rises during WB or ALLOC, the refill completes first. FLUSH is entered from the following IDLE cycle.
- If nRST falls mid-transfer, all state clears asynchronously and the memory outputs drop the same cycle.

## Configuration
- PDCACHE_HITCNT_EN defined:
  - A 32-bit counter increments on every IDLE cycle with dhit=1 and wraps modulo 2^32.
  - After the flush scan, state CNT writes the counter to daddr=32'h3100 (one transfer), then goes to DONE.
- PDCACHE_HITCNT_EN undefined: no counter and no CNT state; the flush goes straight to DONE.

## Structure
- Shared package cpu_types_pkg holds word_t, the state enum (IDLE, WB, ALLOC, FLUSH, CNT, DONE) and HITCNT_ADDR=32'h3100.
- The line struct depends on the parameters and is local to the module.
- One sub-module, pdcache_array, holds the two-way storage, tag compare and LRU bits. It has a combinational read port and a synchronous write port.

## Test plan
- Cold read 0x40, dload=0xA5A50000+word index → ALLOC fetches 0x40 and 0x44 (BLKWORDS=2). The next cycle gives dhit=1 and dmemload=0xA5A50000.
- Write 0x40 =0x1234 after fill → dhit same cycle. A subsequent read of 0x40 returns 0x1234 with no memory traffic.
- Dirty set 0 in both ways, then a third-tag miss to set 0 → WB of the LRU way's two words at its old address, then ALLOC. dwait=1 for 3 cycles per transfer holds daddr stable.
- halt with 3 dirty lines → exactly 6 dWEN transfers in set/way order. With PDCACHE_HITCNT_EN, a 7th write carries daddr=0x3100 and dstore=hit count. flushed=1 follows.
- Run with SETS=16, BLKWORDS=4: a miss fetches 4 consecutive words, and addresses 0x0 and 0x100 map to the same set in different ways.
- nRST pulsed mid-ALLOC → dREN=0 immediately. A re-read of the same address misses and refills.
